// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter: a small byte FIFO feeding a start/data/stop frame engine.
// Bits are LSB first, each lasting CLKS_PER_BIT clock-enabled cycles; tx idles high.
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rstB,
  input  logic                          clkEn,
  input  logic                          wr_en,
  input  logic [7:0]                    wr_data,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          busy,
  output logic                          tx
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  state_t          state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [7:0]      shift;
  logic [2:0]      bit_idx;
  logic [BW-1:0]   bcnt;
  logic            bit_end;
  logic            pop;
  logic            push;

  assign bit_end = (bcnt == BW'(CLKS_PER_BIT - 1));
  assign full    = (count == CW'(FIFO_DEPTH));
  assign busy    = (state != IDLE) || (count != '0);

  // A pop only happens when the engine is ready for a new byte, which lets a full FIFO accept a write on that same edge.
  always_comb begin
    state_next = state;
    pop        = 1'b0;
    if (clkEn) begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            pop        = 1'b1;
            state_next = START;
          end
        end
        START: if (bit_end) state_next = DATA;
        DATA:  if (bit_end && bit_idx == 3'd7) state_next = STOP;
        STOP: begin
          if (bit_end) begin
            if (count != '0) begin
              pop        = 1'b1;
              state_next = START;
            end else begin
              state_next = IDLE;
            end
          end
        end
        default: state_next = IDLE;
      endcase
    end
    push = clkEn && wr_en && (!full || pop);
  end

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clkEn) begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (wr_en && !push) overflow <= 1'b1;
    end
  end

  // The popped byte is latched into shift so later FIFO writes cannot disturb the frame in flight.
  always_ff @(posedge clk or negedge rstB) begin
    if (!rstB) begin
      tx      <= 1'b1;
      bcnt    <= '0;
      shift   <= '0;
      bit_idx <= '0;
    end else if (clkEn) begin
      case (state)
        IDLE: begin
          bcnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
            tx    <= 1'b0;
          end else begin
            tx <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            bcnt    <= '0;
            bit_idx <= '0;
            tx      <= shift[0];
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        DATA: begin
          if (bit_end) begin
            bcnt <= '0;
            if (bit_idx == 3'd7) begin
              tx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        STOP: begin
          if (bit_end) begin
            bcnt <= '0;
            if (pop) begin
              shift <= mem[rd_ptr];
              tx    <= 1'b0;
            end else begin
              tx <= 1'b1;
            end
          end else begin
            bcnt <= bcnt + BW'(1);
          end
        end
        default: tx <= 1'b1;
      endcase
    end
  end

endmodule
